nonce_irq_queue: RTL and testbench
==================================

NONCE_IRQ_QUEUE -- requirements
Module: nonce_irq_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, 2..64).
REQ-002 SHALL have parameter NONCE_W, default 64, nonce width.
REQ-003 SHALL have port S_AXI_ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_nonce_vld0  in  1  core 0 good-nonce strobe, one cycle per nonce.
REQ-006 SHALL have port i_nonce0  in  NONCE_W  core 0 nonce, valid with strobe.
REQ-007 SHALL have port i_nonce_vld1  in  1  core 1 good-nonce strobe.
REQ-008 SHALL have port i_nonce1  in  NONCE_W  core 1 nonce.
REQ-009 SHALL have port i_flush  in  1  new-work flush, synchronous, level.
REQ-010 SHALL have port interrupts  out  4  interrupt lines to the UART/AXI master.
REQ-011 SHALL have port interuptZeroData  out  NONCE_W  head-of-queue nonce.
REQ-012 SHALL have port interuptZeroAck  in  1  master consumed head, one-cycle pulse.
REQ-013 SHALL have port o_level  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port o_drop_count  out  16  nonces lost to overflow.

Function
REQ-015 SHALL raise interrupts[0] whenever occupancy > 0, deasserting the cycle after the last entry is popped.
REQ-016 SHALL raise interrupts[1] as sticky overflow flag, set on any drop, cleared only by reset or i_flush.
REQ-017 SHALL drive interrupts[3:2] to 0.
REQ-018 SHALL present head entry on interuptZeroData from a register; value stable while interrupts[0]=1 and no ack; 0 when empty.
REQ-019 SHALL write a strobed nonce at the clock edge; entry visible on interrupts[0]/data one cycle later (latency 1).
REQ-020 SHALL, on simultaneous strobes, enqueue core 0 then core 1 in that order.
REQ-021 SHALL, on interuptZeroAck with occupancy > 0, pop head; next entry on interuptZeroData the following cycle.
REQ-022 SHALL ignore interuptZeroAck when empty (no underflow, no state change).
REQ-023 SHALL evaluate pop before push: free space = DEPTH - occupancy + (ack and nonempty).
REQ-024 SHALL, with free space 1 and both strobes, keep core 0, drop core 1; with free space 0, drop all strobed nonces.
REQ-025 SHALL add the number of dropped nonces (0..2) to o_drop_count per cycle, saturating at 16'hFFFF.
REQ-026 SHALL, when i_flush=1, empty queue, discard same-cycle pushes and ack, clear interrupts[1]; o_drop_count unchanged.
REQ-027 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-028 SHALL never modify an entry between write and pop.

Reset
REQ-029 SHALL, on S_AXI_ARESETN=0, asynchronously clear pointers, o_level=0, interrupts=0, interuptZeroData=0, o_drop_count=0.
REQ-030 SHALL, on reset mid-operation, discard all queued entries; first strobe after deassertion treated as into empty queue.
REQ-031 SHALL leave storage array unreset (contents don't-care when invalid).

Structure
REQ-032 SHALL take DEPTH/NONCE_W defaults, interrupt bit indices (IRQ_NONCE=0, IRQ_OVF=1) and drop counter width from shared package nexus_irq_pkg.
REQ-033 SHALL implement storage as one sub-module nonce_fifo2w (two-write-port, one-read-port synchronous FIFO with level output); drop/irq logic in top.

Verification
REQ-034 Single push: vld0, nonce0=64'h0000_0000_DEAD_BEEF -> next cycle interrupts=4'b0001, data=DEADBEEF; ack -> interrupts=0, data=0 next cycle.
REQ-035 Dual push: vld0 nonce0=1 and vld1 nonce1=2 same cycle -> o_level=2, data=1; ack -> data=2; ack -> empty.
REQ-036 Overflow: DEPTH=8, 7 entries, both strobes -> o_level=8, core 0 stored, o_drop_count=1, interrupts[1]=1; further dual strobe -> drop_count=3.
REQ-037 Full + ack + single push same cycle -> o_level stays 8, no drop, order preserved over 20 pops with pointer wrap.
REQ-038 Flush with 5 entries and concurrent strobe -> o_level=0, interrupts=0, o_drop_count unchanged; ack on empty -> no change.
REQ-039 Assert S_AXI_ARESETN low mid-burst asynchronously -> all outputs 0 before next edge; drop counter saturation checked at 16'hFFFF.

Source files
------------

// File: rtl/nexus_irq_pkg.sv
// Shared constants for the nonce interrupt path: default sizing, interrupt
// bit positions and the saturating drop-counter arithmetic.
package nexus_irq_pkg;

  localparam int unsigned DEPTH_DEFAULT   = 8;
  localparam int unsigned NONCE_W_DEFAULT = 64;
  localparam int unsigned IRQ_NONCE       = 0;
  localparam int unsigned IRQ_OVF         = 1;
  localparam int unsigned DROP_W          = 16;

  // Adds 0..2 dropped nonces, sticking at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                      input logic [1:0]        n);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, n};
    return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/nonce_fifo2w.sv
// Two-write-port, one-read-port synchronous FIFO with a registered head
// output (zero when empty) and an occupancy count. Callers never overfill it.
module nonce_fifo2w
  import nexus_irq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = NONCE_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     we0,
  input  logic [W-1:0]             wd0,
  input  logic                     we1,
  input  logic [W-1:0]             wd1,
  input  logic                     re,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rp, wp, rp_n, wp1, wp_n;
  logic [AW:0]   level_n;
  logic [W-1:0]  head_n;

  // Head is precomputed for the next cycle; a write landing on the new read
  // slot bypasses the array so a push into an empty queue shows up after one edge.
  always_comb begin
    rp_n    = rp + AW'(re);
    wp1     = wp + AW'(we0);
    wp_n    = wp1 + AW'(we1);
    level_n = level - (AW+1)'(re) + (AW+1)'(we0) + (AW+1)'(we1);
    if (level_n == '0)
      head_n = '0;
    else if (we0 && (wp == rp_n))
      head_n = wd0;
    else if (we1 && (wp1 == rp_n))
      head_n = wd1;
    else
      head_n = mem[rp_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
      head  <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
      head  <= '0;
    end else begin
      rp    <= rp_n;
      wp    <= wp_n;
      level <= level_n;
      head  <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem[wp]  <= wd0;
    if (we1) mem[wp1] <= wd1;
  end

endmodule

// File: rtl/nonce_irq_queue.sv
// Collects good nonces from two hashing cores into a queue for the host,
// with overflow accounting and interrupt generation.
module nonce_irq_queue
  import nexus_irq_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned NONCE_W = NONCE_W_DEFAULT
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     i_nonce_vld0,
  input  logic [NONCE_W-1:0]       i_nonce0,
  input  logic                     i_nonce_vld1,
  input  logic [NONCE_W-1:0]       i_nonce1,
  input  logic                     i_flush,
  output logic [3:0]               interrupts,
  output logic [NONCE_W-1:0]       interuptZeroData,
  input  logic                     interuptZeroAck,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [DROP_W-1:0]        o_drop_count
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          pop, acc0, acc1, ovf;
  logic [LW:0]   free;
  logic [1:0]    drops;

  // Pop is credited before pushes, so a full queue with an ack takes one nonce.
  always_comb begin
    pop   = interuptZeroAck && (o_level != '0) && !i_flush;
    free  = (LW+1)'(DEPTH) - {1'b0, o_level} + (LW+1)'(pop);
    acc0  = i_nonce_vld0 && !i_flush && (free != '0);
    acc1  = i_nonce_vld1 && !i_flush && (free > (LW+1)'(acc0));
    drops = i_flush ? 2'd0
                    : ({1'b0, i_nonce_vld0 && !acc0} + {1'b0, i_nonce_vld1 && !acc1});
  end

  nonce_fifo2w #(
    .DEPTH (DEPTH),
    .W     (NONCE_W)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .flush (i_flush),
    .we0   (acc0),
    .wd0   (i_nonce0),
    .we1   (acc1),
    .wd1   (i_nonce1),
    .re    (pop),
    .head  (interuptZeroData),
    .level (o_level)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ovf          <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_drop_count <= sat_add_drop(o_drop_count, drops);
      if (i_flush)
        ovf <= 1'b0;
      else if (drops != 2'd0)
        ovf <= 1'b1;
    end
  end

  always_comb begin
    interrupts            = '0;
    interrupts[IRQ_NONCE] = (o_level != '0);
    interrupts[IRQ_OVF]   = ovf;
  end

endmodule

// File: tb/tb_nonce_irq_queue.sv
// Randomised and directed bench for nonce_irq_queue against a queue-based model.
module tb_nonce_irq_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NW    = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vld0, vld1, flush, ack;
  logic [NW-1:0] nonce0, nonce1;
  logic [3:0]    interrupts;
  logic [NW-1:0] data;
  logic [3:0]    level;
  logic [15:0]   drop_count;

  int compared   = 0;
  int mismatched = 0;

  logic [NW-1:0] mq[$];
  bit            movf;
  int            mdrop;

  always #5 clk = ~clk;

  nonce_irq_queue #(.DEPTH(DEPTH), .NONCE_W(NW)) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .i_nonce_vld0     (vld0),
    .i_nonce0         (nonce0),
    .i_nonce_vld1     (vld1),
    .i_nonce1         (nonce1),
    .i_flush          (flush),
    .interrupts       (interrupts),
    .interuptZeroData (data),
    .interuptZeroAck  (ack),
    .o_level          (level),
    .o_drop_count     (drop_count)
  );

  task automatic model_step(input bit v0, input logic [NW-1:0] n0,
                            input bit v1, input logic [NW-1:0] n1,
                            input bit a, input bit fl);
    if (fl) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (a && mq.size() > 0) void'(mq.pop_front());
      if (v0) begin
        if (mq.size() < DEPTH) mq.push_back(n0);
        else begin mdrop++; movf = 1'b1; end
      end
      if (v1) begin
        if (mq.size() < DEPTH) mq.push_back(n1);
        else begin mdrop++; movf = 1'b1; end
      end
      if (mdrop > 65535) mdrop = 65535;
    end
  endtask

  task automatic drive(input bit v0, input logic [NW-1:0] n0,
                       input bit v1, input logic [NW-1:0] n1,
                       input bit a, input bit fl);
    vld0 = v0; nonce0 = n0; vld1 = v1; nonce1 = n1; ack = a; flush = fl;
    model_step(v0, n0, v1, n1, a, fl);
    @(posedge clk); #1;
    vld0 = 0; vld1 = 0; ack = 0; flush = 0;
    nonce0 = '0; nonce1 = '0;
  endtask

  task automatic test_reset;
    rst_n = 0; vld0 = 0; vld1 = 0; ack = 0; flush = 0; nonce0 = '0; nonce1 = '0;
    mq.delete(); movf = 0; mdrop = 0;
    #22;
    compared++; if (interrupts !== 4'b0000) begin mismatched++; $display("FAIL reset_irq got %b want 0000", interrupts); end
    compared++; if (data !== '0) begin mismatched++; $display("FAIL reset_data got %h want 0", data); end
    compared++; if (level !== 4'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", level); end
    compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_push;
    drive(1, 64'h0000_0000_DEAD_BEEF, 0, '0, 0, 0);
    compared++; if (interrupts !== 4'b0001) begin mismatched++; $display("FAIL single_irq got %b want 0001", interrupts); end
    compared++; if (data !== 64'h0000_0000_DEAD_BEEF) begin mismatched++; $display("FAIL single_data got %h want deadbeef", data); end
    drive(0, '0, 0, '0, 1, 0);
    compared++; if (interrupts !== 4'b0000) begin mismatched++; $display("FAIL single_pop_irq got %b want 0000", interrupts); end
    compared++; if (data !== '0) begin mismatched++; $display("FAIL single_pop_data got %h want 0", data); end
  endtask

  task automatic test_dual_push;
    drive(1, 64'd1, 1, 64'd2, 0, 0);
    compared++; if (level !== 4'd2) begin mismatched++; $display("FAIL dual_level got %0d want 2", level); end
    compared++; if (data !== 64'd1) begin mismatched++; $display("FAIL dual_head got %0d want 1", data); end
    drive(0, '0, 0, '0, 1, 0);
    compared++; if (data !== 64'd2) begin mismatched++; $display("FAIL dual_second got %0d want 2", data); end
    drive(0, '0, 0, '0, 1, 0);
    compared++; if (level !== 4'd0 || data !== '0) begin mismatched++; $display("FAIL dual_empty got lvl %0d data %0d want 0/0", level, data); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 7; i++) drive(1, 64'(100 + i), 0, '0, 0, 0);
    compared++; if (level !== 4'd7) begin mismatched++; $display("FAIL ovf_fill got %0d want 7", level); end
    drive(1, 64'd200, 1, 64'd201, 0, 0);
    compared++; if (level !== 4'd8) begin mismatched++; $display("FAIL ovf_level got %0d want 8", level); end
    compared++; if (drop_count !== 16'd1) begin mismatched++; $display("FAIL ovf_drop1 got %0d want 1", drop_count); end
    compared++; if (interrupts !== 4'b0011) begin mismatched++; $display("FAIL ovf_irq got %b want 0011", interrupts); end
    compared++; if (data !== 64'd100) begin mismatched++; $display("FAIL ovf_head got %0d want 100", data); end
    drive(1, 64'd210, 1, 64'd211, 0, 0);
    compared++; if (drop_count !== 16'd3) begin mismatched++; $display("FAIL ovf_drop3 got %0d want 3", drop_count); end
  endtask

  task automatic test_full_ack_push;
    drive(1, 64'd300, 0, '0, 1, 0);
    compared++; if (level !== 4'd8) begin mismatched++; $display("FAIL fap_level got %0d want 8", level); end
    compared++; if (drop_count !== 16'd3) begin mismatched++; $display("FAIL fap_drop got %0d want 3", drop_count); end
    compared++; if (data !== 64'd101) begin mismatched++; $display("FAIL fap_head got %0d want 101", data); end
    for (int i = 0; i < 20; i++) begin
      drive(1, 64'(400 + i), 0, '0, 1, 0);
      compared++;
      if (level !== 4'd8 || data !== mq[0] || drop_count !== 16'd3) begin
        mismatched++;
        $display("FAIL fap_wrap[%0d] got lvl %0d data %0d drop %0d want 8/%0d/3", i, level, data, drop_count, mq[0]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 0, '0, 1, 0);
      compared++;
      if (data !== (mq.size() > 0 ? mq[0] : '0) || level !== 4'(mq.size())) begin
        mismatched++;
        $display("FAIL fap_drain[%0d] got lvl %0d data %0d want %0d", i, level, data, mq.size());
      end
    end
  endtask

  task automatic test_flush;
    int drop_before;
    for (int i = 0; i < 5; i++) drive(1, 64'(500 + i), 0, '0, 0, 0);
    compared++; if (level !== 4'd5) begin mismatched++; $display("FAIL flush_fill got %0d want 5", level); end
    drop_before = mdrop;
    drive(1, 64'd600, 1, 64'd601, 1, 1);
    compared++; if (level !== 4'd0) begin mismatched++; $display("FAIL flush_level got %0d want 0", level); end
    compared++; if (interrupts !== 4'b0000) begin mismatched++; $display("FAIL flush_irq got %b want 0000", interrupts); end
    compared++; if (drop_count !== 16'(drop_before)) begin mismatched++; $display("FAIL flush_drop got %0d want %0d", drop_count, drop_before); end
    drive(0, '0, 0, '0, 1, 0);
    compared++;
    if (level !== 4'd0 || data !== '0 || interrupts !== 4'b0000 || drop_count !== 16'(drop_before)) begin
      mismatched++;
      $display("FAIL empty_ack got lvl %0d data %0d irq %b drop %0d want 0/0/0000/%0d", level, data, interrupts, drop_count, drop_before);
    end
  endtask

  task automatic test_random;
    bit v0, v1, a, fl;
    logic [NW-1:0] n0, n1;
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 99) < 45);
      v1 = ($urandom_range(0, 99) < 35);
      a  = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 99) < 2);
      n0 = {$urandom, $urandom};
      n1 = {$urandom, $urandom};
      drive(v0, n0, v1, n1, a, fl);
      compared++;
      if (level !== 4'(mq.size()) || data !== (mq.size() > 0 ? mq[0] : '0) ||
          interrupts !== {2'b00, movf, mq.size() > 0} || drop_count !== 16'(mdrop)) begin
        mismatched++;
        $display("FAIL random[%0d] got lvl %0d data %h irq %b drop %0d want lvl %0d data %h irq %b drop %0d",
                 i, level, data, interrupts, drop_count, mq.size(),
                 (mq.size() > 0 ? mq[0] : '0), {2'b00, movf, mq.size() > 0}, mdrop);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(1, 64'd11, 1, 64'd12, 0, 0);
    drive(1, 64'd13, 0, '0, 0, 0);
    #2 rst_n = 0;
    #1;
    compared++;
    if (interrupts !== 4'b0000 || data !== '0 || level !== 4'd0 || drop_count !== 16'd0) begin
      mismatched++;
      $display("FAIL async_reset got irq %b data %h lvl %0d drop %0d want all 0", interrupts, data, level, drop_count);
    end
    mq.delete(); movf = 0; mdrop = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    drive(1, 64'h55, 0, '0, 0, 0);
    compared++;
    if (level !== 4'd1 || data !== 64'h55 || interrupts !== 4'b0001) begin
      mismatched++;
      $display("FAIL post_reset_push got lvl %0d data %h irq %b want 1/55/0001", level, data, interrupts);
    end
  endtask

  task automatic test_saturation;
    while (mq.size() < DEPTH) drive(1, {$urandom, $urandom}, 0, '0, 0, 0);
    for (int i = 0; i < 33000; i++) drive(1, 64'(i), 1, 64'(i), 0, 0);
    compared++; if (drop_count !== 16'hFFFF) begin mismatched++; $display("FAIL sat_drop got %h want ffff", drop_count); end
    drive(1, '0, 1, '0, 0, 0);
    compared++; if (drop_count !== 16'hFFFF) begin mismatched++; $display("FAIL sat_hold got %h want ffff", drop_count); end
    compared++; if (interrupts !== 4'b0011 || level !== 4'd8) begin mismatched++; $display("FAIL sat_state got irq %b lvl %0d want 0011/8", interrupts, level); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_dual_push();
    test_overflow();
    test_full_ack_push();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
